// File: rtl/cla_pkg.sv
// Shared widths and record types for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int CLA_N   = 64;
  localparam int CLA_BLK = 4;
  localparam int NUM_BLK = CLA_N / CLA_BLK;

  typedef struct packed {
    logic p;
    logic g;
  } grp_pg_t;

  typedef struct packed {
    logic [CLA_N-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
  } cla_result_t;

endpackage

// File: rtl/Sum_blk.sv
// Final sum stage: each sum bit is its propagate bit XOR its incoming carry.
module Sum_blk #(
  parameter int N = 64
) (
  input  logic [N-1:0] p_i,
  input  logic [N-1:0] cin,
  output logic [N-1:0] sum_o
);

  assign sum_o = p_i ^ cin;

endmodule

// File: rtl/cla_carry_unit.sv
// Two-level carry lookahead: group P/G per block, then per-bit carries
// derived from each block's carry-in.
module cla_carry_unit
  import cla_pkg::*;
#(
  parameter int N   = CLA_N,
  parameter int BLK = CLA_BLK
) (
  input  logic [N-1:0] p_i,
  input  logic [N-1:0] g_i,
  input  logic         cin_i,
  output logic [N-1:0] c_o,
  output logic         cout_o
);

  localparam int NB = N / BLK;

  // NOTE: blocking assignments here are deliberate; the loop variables carry
  // values from one iteration to the next, which only works in combinational
  // code where each statement sees the previous one's result immediately.
  always_comb begin
    grp_pg_t w_grp;
    logic    w_blk_c;
    logic    w_run_p;
    logic    w_run_g;
    c_o     = '0;
    w_grp   = '0;
    w_blk_c = cin_i;
    w_run_p = 1'b1;
    w_run_g = 1'b0;
    for (int j = 0; j < NB; j++) begin
      w_run_p = 1'b1;
      w_run_g = 1'b0;
      // Carry into bit k of the block = generate(0..k-1) | propagate(0..k-1) & C[j].
      for (int k = 0; k < BLK; k++) begin
        c_o[j*BLK+k] = w_run_g | (w_run_p & w_blk_c);
        w_run_g      = g_i[j*BLK+k] | (p_i[j*BLK+k] & w_run_g);
        w_run_p      = w_run_p & p_i[j*BLK+k];
      end
      w_grp.p = &p_i[j*BLK +: BLK];
      w_grp.g = w_run_g;
      w_blk_c = w_grp.g | (w_grp.p & w_blk_c);
    end
    cout_o = w_blk_c;
  end

endmodule

// File: rtl/cla64_pipe.sv
// Two-stage pipelined carry-lookahead adder with valid/ready on both sides.
// N must match cla_pkg::CLA_N because the result record is sized from it.
module cla64_pipe
  import cla_pkg::*;
#(
  parameter int N   = CLA_N,
  parameter int BLK = CLA_BLK
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         cin_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o,
  output logic         ovf_o,
  output logic         zero_o
);

  logic         r_s1_valid;
  logic [N-1:0] r_s1_p;
  logic [N-1:0] r_s1_g;
  logic         r_s1_cin;
  logic         r_out_valid;
  cla_result_t  r_res;

  logic         w_s2_ready;
  logic         w_in_xfer;
  logic         w_s2_load;
  logic [N-1:0] w_carry;
  logic [N-1:0] w_sum;
  logic         w_cout;
  cla_result_t  w_res;

  assign w_s2_ready = !r_out_valid || out_ready_i;
  assign in_ready_o = !r_s1_valid || w_s2_ready;
  assign w_in_xfer  = in_valid_i && in_ready_o;
  assign w_s2_load  = r_s1_valid && w_s2_ready;

  // NOTE: the stage-1 datapath has no reset; r_s1_valid alone decides whether
  // its contents mean anything, so clearing them would only cost wiring.
  always_ff @(posedge clk) begin
    if (w_in_xfer) begin
      r_s1_p   <= a_i ^ b_i;
      r_s1_g   <= a_i & b_i;
      r_s1_cin <= cin_i;
    end
  end

  cla_carry_unit #(.N(N), .BLK(BLK)) u_carry (
    .p_i    (r_s1_p),
    .g_i    (r_s1_g),
    .cin_i  (r_s1_cin),
    .c_o    (w_carry),
    .cout_o (w_cout)
  );

  Sum_blk #(.N(N)) u_sum (
    .p_i   (r_s1_p),
    .cin   (w_carry),
    .sum_o (w_sum)
  );

  always_comb begin
    w_res      = '0;
    w_res.sum  = w_sum;
    w_res.cout = w_cout;
    w_res.ovf  = w_carry[N-1] ^ w_cout;
    w_res.zero = (w_sum == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid  <= 1'b0;
      r_out_valid <= 1'b0;
      r_res       <= '0;
    end else begin
      if (w_in_xfer) begin
        r_s1_valid <= 1'b1;
      end else if (w_s2_load) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s2_load) begin
        r_out_valid <= 1'b1;
        r_res       <= w_res;
      end else if (out_ready_i) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid_o = r_out_valid;
  assign sum_o       = r_res.sum;
  assign cout_o      = r_res.cout;
  assign ovf_o       = r_res.ovf;
  assign zero_o      = r_res.zero;

endmodule

// File: tb/tb_cla64_pipe.sv
// Self-checking bench: directed vector table, stall and reset sequences,
// and a randomized stream scored against an arithmetic reference.
module tb_cla64_pipe;

  localparam int N = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [N-1:0] a_i;
  logic [N-1:0] b_i;
  logic         cin_i;
  logic         out_valid_o;
  logic         out_ready_i;
  logic [N-1:0] sum_o;
  logic         cout_o;
  logic         ovf_o;
  logic         zero_o;

  always #5 clk = ~clk;

  cla64_pipe #(.N(N), .BLK(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .cin_i       (cin_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .sum_o       (sum_o),
    .cout_o      (cout_o),
    .ovf_o       (ovf_o),
    .zero_o      (zero_o)
  );

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } vec_t;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Reference: plain wide addition; overflow from operand/result signs.
  function automatic logic [66:0] ref_add(input logic [63:0] a, input logic [63:0] b,
                                          input logic cin);
    logic [64:0] t;
    logic [63:0] s;
    logic        ovf;
    t   = {1'b0, a} + {1'b0, b} + 65'(cin);
    s   = t[63:0];
    ovf = (a[63] == b[63]) && (s[63] != a[63]);
    return {t[64], ovf, (s == 64'd0), s};
  endfunction

  logic [66:0] exp_q[$];
  logic [66:0] sb_exp;
  bit          sb_en = 1'b0;
  int          n_out = 0;

  always @(negedge clk) begin
    if (sb_en && !rst) begin
      if (out_valid_o && out_ready_i) begin
        n_out++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected_beat", 128'(out_valid_o), 128'(1'b0));
        end else begin
          sb_exp = exp_q.pop_front();
          check("sb_result", 128'({cout_o, ovf_o, zero_o, sum_o}), 128'(sb_exp));
        end
      end
      if (in_valid_i && in_ready_o) exp_q.push_back(ref_add(a_i, b_i, cin_i));
    end
  end

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    @(posedge clk); #1;
    a_i = v.a; b_i = v.b; cin_i = v.cin; in_valid_i = 1'b1; out_ready_i = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, 128'(in_ready_o), 128'(1'b1));
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    lat = 0;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      if (out_valid_o) break;
      @(posedge clk);
      lat++;
    end
    check({tag, "_latency"}, 128'(lat), 128'(1));
    check({tag, "_result"}, 128'({cout_o, ovf_o, zero_o, sum_o}),
          128'({v.cout, v.ovf, v.zero, v.sum}));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  vec_t        vecs[8];
  logic [63:0] sa[4];
  logic [63:0] sb[4];
  logic [66:0] e0;
  bit          acc;
  int          sent;
  int          cyc;

  initial begin
    rst = 1'b1; in_valid_i = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0; out_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 128'(out_valid_o), 128'(1'b0));
    check("reset_outputs", 128'({cout_o, ovf_o, zero_o, sum_o}), 128'(0));
    check("reset_in_ready", 128'(in_ready_o), 128'(1'b1));

    vecs[0] = '{64'h5, 64'h3, 1'b0, 64'h8, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1, 1'b1};
    vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{64'h0F0F_0F0F_0F0F_0F0F, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0,
                64'h1E1E_1E1E_1E1E_1E1E, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{64'h0000_0000_FFFF_FFFF, 64'h0, 1'b1, 64'h0000_0001_0000_0000, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFE, 64'h1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back stream with the consumer stalled for three edges.
    sa[0] = 64'h1111; sa[1] = 64'hFFFF_0000_FFFF_0000; sa[2] = 64'h7; sa[3] = 64'hABCD_EF01_2345_6789;
    sb[0] = 64'h2222; sb[1] = 64'h0001_0000_0001_0000; sb[2] = 64'h9; sb[3] = 64'h1111_1111_1111_1111;
    e0 = ref_add(sa[0], sb[0], 1'b0);
    @(posedge clk); #1;
    exp_q.delete(); n_out = 0; sb_en = 1'b1;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          a_i = sa[i]; b_i = sb[i]; cin_i = i[0]; in_valid_i = 1'b1;
          acc = 1'b0;
          for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            acc = in_ready_o;
            @(posedge clk); #1;
          end
        end
        in_valid_i = 1'b0;
      end
      begin
        out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("stall_in_ready", 128'(in_ready_o), 128'(1'b0));
        check("stall_out_valid", 128'(out_valid_o), 128'(1'b1));
        check("stall_first", 128'({cout_o, ovf_o, zero_o, sum_o}), 128'(e0));
        @(posedge clk);
        @(negedge clk);
        check("stall_hold", 128'({out_valid_o, cout_o, ovf_o, zero_o, sum_o}), 128'({1'b1, e0}));
        check("stall_in_ready_hold", 128'(in_ready_o), 128'(1'b0));
        @(posedge clk); #1;
        out_ready_i = 1'b1;
      end
    join
    for (int t = 0; t < 50 && n_out < 4; t++) @(posedge clk);
    @(negedge clk);
    check("stall_count", 128'(n_out), 128'(4));
    check("stall_leftover", 128'(exp_q.size()), 128'(0));
    sb_en = 1'b0;

    // Reset with both stages holding beats.
    @(posedge clk); #1;
    out_ready_i = 1'b0; in_valid_i = 1'b1; a_i = 64'h10; b_i = 64'h20; cin_i = 1'b0;
    @(posedge clk); #1;
    a_i = 64'h30;
    @(posedge clk); #1;
    in_valid_i = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("rst_pre_full", 128'({out_valid_o, in_ready_o}), 128'(2'b10));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 128'(out_valid_o), 128'(1'b0));
    check("rst_outputs", 128'({cout_o, ovf_o, zero_o, sum_o}), 128'(0));
    check("rst_in_ready", 128'(in_ready_o), 128'(1'b1));
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    @(negedge clk);
    check("rst_no_ghost", 128'(out_valid_o), 128'(1'b0));
    run_vec('{64'h1, 64'h1, 1'b0, 64'h2, 1'b0, 1'b0, 1'b0}, "rst_after");

    // Randomized stream with random back-pressure.
    @(posedge clk); #1;
    in_valid_i = 1'b0; exp_q.delete(); n_out = 0; sent = 0; cyc = 0; sb_en = 1'b1;
    while (sent < 1000 && cyc < 20000) begin
      if (!in_valid_i && $urandom_range(3) != 0) begin
        a_i = {$urandom, $urandom};
        b_i = {$urandom, $urandom};
        case ($urandom_range(7))
          0: a_i = '1;
          1: b_i = ~a_i;
          2: a_i = 64'h7FFF_FFFF_FFFF_FFFF;
          default: ;
        endcase
        cin_i = 1'($urandom_range(1));
        in_valid_i = 1'b1;
      end
      out_ready_i = ($urandom_range(3) != 0);
      @(negedge clk);
      acc = in_valid_i && in_ready_o;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        in_valid_i = 1'b0;
      end
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
    @(negedge clk);
    check("rand_leftover", 128'(exp_q.size()), 128'(0));
    check("rand_count", 128'(n_out), 128'(1000));
    sb_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
